// File: rtl/result_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// result_bus_arbiter_pkg
// Shared types for the execution-unit result path and the common data bus.
//   cond_exception_t : OV/CA flags plus their valid bits and CR0_valid, as
//                      raised by an execution unit alongside its result.
//   cr0_t            : CR0 field {LT, GT, EQ, SO}, LT in the MSB.
//   cdb_packet_t     : one CDB broadcast entry, using the default tag width.
//   calc_cr0()       : CR0 derivation from a 32-bit result and the SO sources.
// -----------------------------------------------------------------------------
package result_bus_arbiter_pkg;

    localparam int RS_ID_WIDTH_DEF = 5;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int DATA_WIDTH      = 32;

    typedef struct packed {
        logic ov;
        logic ov_valid;
        logic ca;
        logic ca_valid;
        logic cr0_valid;
    } cond_exception_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } cr0_t;

    typedef struct packed {
        logic [RS_ID_WIDTH_DEF-1:0] rs_id;
        logic [REG_ADDR_WIDTH-1:0]  reg_addr;
        logic [DATA_WIDTH-1:0]      result;
        cond_exception_t            cr0_xer;
        cr0_t                       cr0;
    } cdb_packet_t;

    // LT is the sign bit. PowerPC numbers bits MSB-first, so architectural
    // result bit 0 is result[31] in this little-endian vector.
    // SO is sticky from XER and additionally set by an overflow that the
    // unit marked as valid, so a divide-by-zero shows up immediately.
    function automatic cr0_t calc_cr0(input logic [DATA_WIDTH-1:0] result,
                                      input logic                  xer_so,
                                      input cond_exception_t       cx);
        cr0_t c;
        c.lt = result[DATA_WIDTH-1];
        c.gt = ~result[DATA_WIDTH-1] & (|result);
        c.eq = ~(|result);
        c.so = xer_so | (cx.ov_valid & cx.ov);
        return c;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// result_bus_arbiter_if
// Bundles the execution-unit result ports and the CDB output of the arbiter.
//   unit_valid/unit_ready : per-unit handshake. A unit transfers a result in
//                           any cycle where unit_valid[i] & unit_ready[i].
//                           unit_ready[i] is only ever high with unit_valid[i];
//                           a unit must hold its fields stable while valid.
//   unit_rs_id/reg_addr/result/cr0_xer : per-unit payload.
//   xer_so_in             : architectural XER[SO].
//   cdb_valid/cdb_ready   : CDB handshake; an entry is consumed in a cycle
//                           where both are high, cdb_* stable otherwise.
//   cdb_*                 : registered broadcast of the granted result.
// Modports:
//   master : the environment (execution units and writeback).
//   slave  : the arbiter.
// -----------------------------------------------------------------------------
interface result_bus_arbiter_if
    import result_bus_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);

    logic [NUM_UNITS-1:0]                     unit_valid;
    logic [NUM_UNITS-1:0]                     unit_ready;
    logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]    unit_rs_id;
    logic [NUM_UNITS-1:0][REG_ADDR_WIDTH-1:0] unit_reg_addr;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]     unit_result;
    cond_exception_t [NUM_UNITS-1:0]          unit_cr0_xer;
    logic                                     xer_so_in;

    logic                                     cdb_valid;
    logic                                     cdb_ready;
    logic [RS_ID_WIDTH-1:0]                   cdb_rs_id;
    logic [REG_ADDR_WIDTH-1:0]                cdb_reg_addr;
    logic [DATA_WIDTH-1:0]                    cdb_result;
    cond_exception_t                          cdb_cr0_xer;
    cr0_t                                     cdb_cr0;

    modport master (
        output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
        output xer_so_in, cdb_ready,
        input  unit_ready,
        input  cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_cr0
    );

    modport slave (
        input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
        input  xer_so_in, cdb_ready,
        output unit_ready,
        output cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_cr0
    );

endinterface

// File: rtl/result_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter with an internal priority pointer.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req_i      : [N] request vector
//   advance_i  : the current grant is taken; pointer moves past the winner
//   grant_o    : [N] one-hot grant (all zero when no request)
//   ptr_o      : current pointer, for observation
// The search starts at the pointer and wraps N-1 -> 0, so every requester is
// served within N-1 grants to others. The pointer wraps explicitly, so N need
// not be a power of two.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             found;

    // Two passes: first the units at or above the pointer, then the ones
    // below it. Equivalent to a wrapped search without modulo arithmetic.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                win_idx    = PTR_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_q))) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                win_idx    = PTR_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            if (win_idx == PTR_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/result_bus_arbiter.sv
// -----------------------------------------------------------------------------
// result_bus_arbiter
// Collects results from NUM_UNITS execution units, picks one per cycle by
// round-robin and broadcasts it on a one-entry registered common data bus,
// together with the CR0 field derived from the granted result.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : result_bus_arbiter_if.slave (unit ports, XER[SO], CDB)
//   dbg_rr_ptr_o  : round-robin pointer, for observation
// The CDB register accepts a new entry when it is empty or being consumed
// in the same cycle, which gives back-to-back transfers at full rate.
// -----------------------------------------------------------------------------
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int PTR_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    result_bus_arbiter_if.slave  bus,
    output logic [PTR_W-1:0]     dbg_rr_ptr_o
);

    logic                      accept;
    logic                      load;
    logic [NUM_UNITS-1:0]      grant;

    logic [RS_ID_WIDTH-1:0]    sel_rs_id;
    logic [REG_ADDR_WIDTH-1:0] sel_reg_addr;
    logic [DATA_WIDTH-1:0]     sel_result;
    logic [4:0]                sel_cx_bits;
    cond_exception_t           sel_cx;
    cr0_t                      sel_cr0;

    logic                      cdb_valid_q,    cdb_valid_d;
    logic [RS_ID_WIDTH-1:0]    cdb_rs_id_q,    cdb_rs_id_d;
    logic [REG_ADDR_WIDTH-1:0] cdb_reg_addr_q, cdb_reg_addr_d;
    logic [DATA_WIDTH-1:0]     cdb_result_q,   cdb_result_d;
    cond_exception_t           cdb_cr0_xer_q,  cdb_cr0_xer_d;
    cr0_t                      cdb_cr0_q,      cdb_cr0_d;

    assign accept = ~cdb_valid_q | bus.cdb_ready;
    assign load   = accept & (|bus.unit_valid) & ~rst;

    // The pointer only moves when a grant is actually taken; during reset
    // the arbiter reloads its pointer anyway.
    rr_arbiter #(
        .N     (NUM_UNITS),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.unit_valid),
        .advance_i (accept & ~rst),
        .grant_o   (grant),
        .ptr_o     (dbg_rr_ptr_o)
    );

    assign bus.unit_ready = (accept && !rst) ? grant : '0;

    // Grant is one-hot, so an AND-OR mux selects the winner's fields.
    always_comb begin
        sel_rs_id    = '0;
        sel_reg_addr = '0;
        sel_result   = '0;
        sel_cx_bits  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                sel_rs_id    = sel_rs_id    | bus.unit_rs_id[i];
                sel_reg_addr = sel_reg_addr | bus.unit_reg_addr[i];
                sel_result   = sel_result   | bus.unit_result[i];
                sel_cx_bits  = sel_cx_bits  | bus.unit_cr0_xer[i];
            end
        end
        sel_cx  = cond_exception_t'(sel_cx_bits);
        sel_cr0 = calc_cr0(sel_result, bus.xer_so_in, sel_cx);
    end

    // Valid follows the request whenever the register may take a new entry;
    // data registers only change on an actual load.
    always_comb begin
        cdb_valid_d    = cdb_valid_q;
        cdb_rs_id_d    = cdb_rs_id_q;
        cdb_reg_addr_d = cdb_reg_addr_q;
        cdb_result_d   = cdb_result_q;
        cdb_cr0_xer_d  = cdb_cr0_xer_q;
        cdb_cr0_d      = cdb_cr0_q;
        if (accept) begin
            cdb_valid_d = |bus.unit_valid;
        end
        if (load) begin
            cdb_rs_id_d    = sel_rs_id;
            cdb_reg_addr_d = sel_reg_addr;
            cdb_result_d   = sel_result;
            cdb_cr0_xer_d  = sel_cx;
            cdb_cr0_d      = sel_cr0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q    <= 1'b0;
            cdb_rs_id_q    <= '0;
            cdb_reg_addr_q <= '0;
            cdb_result_q   <= '0;
            cdb_cr0_xer_q  <= '0;
            cdb_cr0_q      <= '0;
        end else begin
            cdb_valid_q    <= cdb_valid_d;
            cdb_rs_id_q    <= cdb_rs_id_d;
            cdb_reg_addr_q <= cdb_reg_addr_d;
            cdb_result_q   <= cdb_result_d;
            cdb_cr0_xer_q  <= cdb_cr0_xer_d;
            cdb_cr0_q      <= cdb_cr0_d;
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_rs_id    = cdb_rs_id_q;
    assign bus.cdb_reg_addr = cdb_reg_addr_q;
    assign bus.cdb_result   = cdb_result_q;
    assign bus.cdb_cr0_xer  = cdb_cr0_xer_q;
    assign bus.cdb_cr0      = cdb_cr0_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_result_bus_arbiter
// Directed table of per-cycle vectors for the result bus arbiter, followed by
// hand-written sequences for CR0 corner cases and reset mid-operation.
// Inputs change on the falling edge; unit_ready is checked 1 time unit later,
// registered CDB outputs 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] ptr;

    int total = 0;
    int bad   = 0;

    result_bus_arbiter_if #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) bus ();

    result_bus_arbiter #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_rr_ptr_o (ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] valid;
        logic       cdb_ready;
        logic [3:0] exp_ready;
        logic       exp_cdb_valid;
        int         exp_src;
        logic [3:0] exp_cr0;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] base_result[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_units();
        for (int i = 0; i < 4; i++) begin
            bus.unit_rs_id[i]    = 5'(i + 3);
            bus.unit_reg_addr[i] = 5'(i + 20);
            bus.unit_result[i]   = base_result[i];
            bus.unit_cr0_xer[i]  = cond_exception_t'(5'b00000);
        end
    endtask

    initial begin
        base_result[0] = 32'h0000_0005;   // GT
        base_result[1] = 32'h8000_0000;   // LT
        base_result[2] = 32'h0000_0000;   // EQ
        base_result[3] = 32'h7FFF_FFFF;   // GT

        //               valid  rdy  exp_rdy  cv  src  cr0      ptr
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 4'b0100, 2'd1};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 4'b1000, 2'd2};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 4'b0010, 2'd3};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 4'b0100, 2'd0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 4'b0100, 2'd1};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 4'b0100, 2'd1};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 4'b0100, 2'd1};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 4'b0100, 2'd1};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 4'b0100, 2'd1};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0, 4'b0100, 2'd1};
        vecs[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 4'b1000, 2'd2};
        vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1, 4'b1000, 2'd2};
        vecs[12] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3, 4'b0100, 2'd0};
        vecs[13] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'b1000, 2'd2};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1, 4'b1000, 2'd2};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1, 4'b1000, 2'd2};

        // reset with everything requesting: nothing may be accepted
        rst            = 1'b1;
        bus.unit_valid = 4'b1111;
        bus.cdb_ready  = 1'b1;
        bus.xer_so_in  = 1'b0;
        load_units();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ready", 64'(bus.unit_ready), 64'h0);
        check("reset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        check("reset_cdb_result", 64'(bus.cdb_result), 64'h0);
        check("reset_cdb_cr0", 64'(bus.cdb_cr0), 64'h0);
        check("reset_ptr", 64'(ptr), 64'h0);
        rst            = 1'b0;
        bus.unit_valid = 4'b0000;

        // table-driven vectors
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            bus.unit_valid = vecs[n].valid;
            bus.cdb_ready  = vecs[n].cdb_ready;
            #1;
            check($sformatf("v%0d_ready", n), 64'(bus.unit_ready), 64'(vecs[n].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cdb_valid", n), 64'(bus.cdb_valid), 64'(vecs[n].exp_cdb_valid));
            check($sformatf("v%0d_result", n), 64'(bus.cdb_result), 64'(base_result[vecs[n].exp_src]));
            check($sformatf("v%0d_rs_id", n), 64'(bus.cdb_rs_id), 64'(vecs[n].exp_src + 3));
            check($sformatf("v%0d_reg_addr", n), 64'(bus.cdb_reg_addr), 64'(vecs[n].exp_src + 20));
            check($sformatf("v%0d_cr0", n), 64'(bus.cdb_cr0), 64'(vecs[n].exp_cr0));
            check($sformatf("v%0d_ptr", n), 64'(ptr), 64'(vecs[n].exp_ptr));
        end

        // single unit, negative result: pointer 2 -> unit 2 granted
        @(negedge clk);
        bus.unit_result[2]  = 32'hFFFF_FFF6;
        bus.unit_cr0_xer[2] = cond_exception_t'(5'b00001);
        bus.unit_valid      = 4'b0100;
        bus.cdb_ready       = 1'b1;
        #1;
        check("single_ready", 64'(bus.unit_ready), 64'h4);
        @(posedge clk);
        #1;
        check("single_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        check("single_result", 64'(bus.cdb_result), 64'hFFFF_FFF6);
        check("single_cr0", 64'(bus.cdb_cr0), 64'b1000);
        check("single_cr0_xer", 64'(bus.cdb_cr0_xer), 64'b00001);
        check("single_ptr", 64'(ptr), 64'd3);
        @(negedge clk);
        bus.unit_valid = 4'b0000;
        #1;
        check("single_ready_drop", 64'(bus.unit_ready), 64'h0);
        @(posedge clk);
        #1;
        check("single_cdb_empty", 64'(bus.cdb_valid), 64'h0);

        // divide by zero: OV with OV_valid sets SO
        @(negedge clk);
        bus.unit_result[0]  = 32'h0;
        bus.unit_cr0_xer[0] = cond_exception_t'(5'b11001);
        bus.unit_valid      = 4'b0001;
        #1;
        check("dz_ready", 64'(bus.unit_ready), 64'h1);
        @(posedge clk);
        #1;
        check("dz_result", 64'(bus.cdb_result), 64'h0);
        check("dz_cr0", 64'(bus.cdb_cr0), 64'b0011);
        check("dz_cr0_xer", 64'(bus.cdb_cr0_xer), 64'b11001);
        // OV without OV_valid: SO stays clear
        @(negedge clk);
        bus.unit_cr0_xer[0] = cond_exception_t'(5'b10001);
        @(posedge clk);
        #1;
        check("ovinv_cr0", 64'(bus.cdb_cr0), 64'b0010);
        // SO from XER alone
        @(negedge clk);
        bus.xer_so_in = 1'b1;
        @(posedge clk);
        #1;
        check("xerso_cr0", 64'(bus.cdb_cr0), 64'b0011);
        @(negedge clk);
        bus.xer_so_in  = 1'b0;
        bus.unit_valid = 4'b0000;
        load_units();

        // reset while the CDB is full and all units pending
        @(negedge clk);
        bus.unit_valid = 4'b1111;
        bus.cdb_ready  = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        @(negedge clk);
        rst           = 1'b1;
        bus.cdb_ready = 1'b1;
        #1;
        check("midrst_ready", 64'(bus.unit_ready), 64'h0);
        @(posedge clk);
        #1;
        check("midrst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        check("midrst_ptr", 64'(ptr), 64'h0);
        check("midrst_result", 64'(bus.cdb_result), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_ready", 64'(bus.unit_ready), 64'h1);
        @(posedge clk);
        #1;
        check("postrst_result", 64'(bus.cdb_result), 64'(base_result[0]));
        check("postrst_ptr", 64'(ptr), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
